fifo_wptr_full: RTL and testbench

//  Write-domain pointer and full-flag generator for the asynchronous FIFO.

---
 rtl/fifo_wptr_full.sv | 91 +++++++++
 tb/tb_fifo_wptr_full.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full
//   Write-domain pointer and full-flag generator for an asynchronous FIFO.
//   Holds the binary write address and the Gray-coded write pointer, and
//   compares them against the read pointer, which has already been
//   synchronised into this clock domain.
//
// Parameters
//   ADDRSIZE   RAM address width; depth = 2**ADDRSIZE, pointers ADDRSIZE+1 bits
//   AF_MARGIN  walmost_full asserts when occupancy >= depth - AF_MARGIN
//
// Ports
//   clk           write-domain clock
//   rst           synchronous reset, active-high
//   winc          write request from client
//   wq2_rptr      Gray read pointer, synchronised to clk
//   wen           RAM write enable (winc & ~wfull), combinational
//   waddr         RAM write address
//   wptr          registered Gray write pointer, to the wptr->rclk synchronizer
//   wfull         registered full flag
//   walmost_full  registered almost-full flag
//   wcount        registered occupancy seen from the write domain
//   overflow      sticky flag: a write was attempted while full
module fifo_wptr_full #(
  parameter int unsigned ADDRSIZE  = 4,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                overflow
);

  localparam int unsigned DEPTH        = 1 << ADDRSIZE;
  localparam int unsigned AF_LEVEL_INT = DEPTH - AF_MARGIN;
  localparam logic [31:0] AF_LEVEL_32  = AF_LEVEL_INT;
  localparam logic [ADDRSIZE:0] AF_LEVEL = AF_LEVEL_32[ADDRSIZE:0];

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbin_n;
  logic [ADDRSIZE:0] wgray_n;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] fill_n;
  logic [ADDRSIZE:0] full_ptr;
  logic              acc;

  assign acc   = winc & ~wfull;
  assign wen   = acc;
  assign waddr = wbin[ADDRSIZE-1:0];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  assign wbin_n  = wbin + {{ADDRSIZE{1'b0}}, acc};
  assign wgray_n = (wbin_n >> 1) ^ wbin_n;
  assign fill_n  = wbin_n - rbin;

  // Full when the next write pointer has lapped the read pointer exactly once:
  // in Gray form that is the two MSBs inverted, the rest equal.
  assign full_ptr = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
      overflow     <= 1'b0;
    end else begin
      wbin         <= wbin_n;
      wptr         <= wgray_n;
      wfull        <= (wgray_n == full_ptr);
      walmost_full <= (fill_n >= AF_LEVEL);
      wcount       <= fill_n;
      overflow     <= overflow | (winc & wfull);
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
module tb_fifo_wptr_full;

  localparam int unsigned A = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         winc;
  logic [A:0]   wq2_rptr;
  logic         wen;
  logic [A-1:0] waddr;
  logic [A:0]   wptr;
  logic         wfull;
  logic         walmost_full;
  logic [A:0]   wcount;
  logic         overflow;

  fifo_wptr_full #(.ADDRSIZE(4), .AF_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wq2_rptr(wq2_rptr),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wcount(wcount), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] wptr;
    logic [4:0] wcount;
    logic [3:0] waddr;
    logic       wfull;
    logic       waf;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // reference model state (binary write count, occupancy arithmetic)
  int unsigned m_wbin = 0;
  bit          m_full = 0;
  bit          m_af   = 0;
  int unsigned m_cnt  = 0;
  bit          m_ovf  = 0;
  bit          m_valid = 0;
  bit          chk_onebit = 0;
  logic [4:0]  prev_wptr;

  function automatic logic [4:0] gray(input int unsigned b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input bit r, input bit w, input int unsigned rb);
    exp_t e;
    exp_t got;
    bit   acc;
    int unsigned nb;
    @(negedge clk);
    rst = r; winc = w; wq2_rptr = gray(rb);
    #1;
    if (m_valid) begin
      check("wen_pre", {31'd0, wen}, {31'd0, w & ~m_full});
      check("waddr_pre", {28'd0, waddr}, m_wbin & 15);
    end
    // model next state
    if (r) begin
      m_wbin = 0; m_full = 0; m_af = 0; m_cnt = 0; m_ovf = 0; m_valid = 1;
    end else begin
      acc    = w && !m_full;
      m_ovf  = m_ovf | (w && m_full);
      nb     = (m_wbin + acc) & 31;
      m_cnt  = (nb - rb) & 31;
      m_full = (m_cnt == 16);
      m_af   = (m_cnt >= 14);
      m_wbin = nb;
    end
    e.wptr = gray(m_wbin); e.wcount = m_cnt[4:0]; e.waddr = m_wbin[3:0];
    e.wfull = m_full; e.waf = m_af; e.ovf = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("wptr", {27'd0, wptr}, {27'd0, got.wptr});
    check("wcount", {27'd0, wcount}, {27'd0, got.wcount});
    check("waddr", {28'd0, waddr}, {28'd0, got.waddr});
    check("wfull", {31'd0, wfull}, {31'd0, got.wfull});
    check("walmost_full", {31'd0, walmost_full}, {31'd0, got.waf});
    check("overflow", {31'd0, overflow}, {31'd0, got.ovf});
    if (chk_onebit) begin
      check("wptr_onebit", $countones(wptr ^ prev_wptr) <= 1, 1);
    end
    prev_wptr = wptr;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; winc = 1'b0; wq2_rptr = '0;

    // 1: reset with winc held high
    step(1, 1, 0);
    step(1, 1, 0);
    check("rst_wptr", {27'd0, wptr}, 0);
    check("rst_wcount", {27'd0, wcount}, 0);
    check("rst_flags", {29'd0, wfull, walmost_full, overflow}, 0);

    // 2: fill 16 with read pointer at 0
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0);
      if (i == 14) begin
        check("fill14_af", {31'd0, walmost_full}, 1);
        check("fill14_cnt", {27'd0, wcount}, 14);
      end
    end
    check("full_flag", {31'd0, wfull}, 1);
    check("full_cnt", {27'd0, wcount}, 16);
    check("full_wptr", {27'd0, wptr}, 32'b11000);

    // 3: writes refused while full, overflow sticky
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      check("ovf_wptr", {27'd0, wptr}, 32'b11000);
      check("ovf_set", {31'd0, overflow}, 1);
    end
    step(0, 0, 0);
    check("ovf_sticky", {31'd0, overflow}, 1);

    // 4: read pointer advances to 4
    step(0, 0, 4);
    check("rel_full", {31'd0, wfull}, 0);
    check("rel_cnt", {27'd0, wcount}, 12);
    check("rel_af", {31'd0, walmost_full}, 0);

    // 5: wrap, reader trailing by 3
    step(1, 0, 0);
    chk_onebit = 1;
    for (int unsigned n = 0; n < 40; n++) begin
      check("wrap_waddr", {28'd0, waddr}, n & 15);
      step(0, 1, (n >= 3) ? n - 3 : 0);
      check("wrap_nofull", {31'd0, wfull}, 0);
    end
    chk_onebit = 0;

    // 6: reset mid-fill
    step(1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0);
    check("mid_cnt", {27'd0, wcount}, 9);
    step(1, 1, 0);
    check("midrst_wptr", {27'd0, wptr}, 0);
    check("midrst_cnt", {27'd0, wcount}, 0);
    check("midrst_full", {31'd0, wfull}, 0);
    check("post_waddr", {28'd0, waddr}, 0);
    step(0, 1, 0);
    check("post_wcount", {27'd0, wcount}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
